// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready on both sides, synchronous flush and a saturating stall counter.
// Define PIPE_STAGE_REG_SKID_EN to add a skid entry so in_ready comes from registered state only.
module pipe_stage_reg #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] main_q, main_nxt;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_xfer;
    logic             stall;

`ifdef PIPE_STAGE_REG_SKID_EN
    logic [WIDTH-1:0] skid_q, skid_nxt;

    assign in_ready = (state != ST_SKID) && !rst;
`else
    assign in_ready = (!valid_q || out_ready) && !rst;
`endif

    assign in_xfer   = in_valid && in_ready;
    assign stall     = valid_q && !out_ready;
    assign out_valid = valid_q;
    assign out_data  = main_q;
    assign stall_cnt = cnt_q;

    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
`ifdef PIPE_STAGE_REG_SKID_EN
        skid_nxt  = skid_q;
`endif
        if (flush) begin
            // flush beats both handshakes; an output transfer this cycle still counts as delivered
            state_nxt = ST_EMPTY;
            main_nxt  = RESET_VAL;
`ifdef PIPE_STAGE_REG_SKID_EN
            skid_nxt  = RESET_VAL;
`endif
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_nxt = ST_FULL;
                        main_nxt  = in_data;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        if (in_xfer) main_nxt = in_data;
                        else         state_nxt = ST_EMPTY;
                    end
`ifdef PIPE_STAGE_REG_SKID_EN
                    else if (in_xfer) begin
                        state_nxt = ST_SKID;
                        skid_nxt  = in_data;
                    end
`endif
                end
`ifdef PIPE_STAGE_REG_SKID_EN
                ST_SKID: begin
                    if (out_ready) begin
                        state_nxt = ST_FULL;
                        main_nxt  = skid_q;
                    end
                end
`endif
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_EMPTY;
            main_q  <= RESET_VAL;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state   <= state_nxt;
            main_q  <= main_nxt;
            valid_q <= (state_nxt != ST_EMPTY);
            // saturate rather than wrap; flush does not touch the count
            if (stall && (cnt_q != {CNT_W{1'b1}}))
                cnt_q <= cnt_q + CNT_W'(1);
        end
    end

`ifdef PIPE_STAGE_REG_SKID_EN
    always_ff @(posedge clk) begin
        if (rst) skid_q <= RESET_VAL;
        else     skid_q <= skid_nxt;
    end
`endif

endmodule
